sq_dist_pipeline: RTL and testbench
===================================

Name: sq_dist_pipeline

Overview:
Streaming, fully pipelined distance engine for the nearest-neighbour search datapath. It computes the squared Euclidean distance between a query point and a vertex point, each with DIM signed coordinates, and sustains one vertex per cycle. Input and output use valid/ready handshakes. A built-in batch minimum tracker reports the closest vertex (distance and tag) at the end of each query batch.

Parameters:
DIM, 4, number of coordinates per point (>=1; non-power-of-two allowed, tree padded with zeros)
IN_WIDTH, 16, signed width of each coordinate
ID_WIDTH, 8, width of the vertex tag carried alongside the data
(localparam) LVL = $clog2(DIM), adder-tree depth (0 when DIM=1)
(localparam) OUT_WIDTH = 2*IN_WIDTH + LVL

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
query_pos_in  input  DIM*IN_WIDTH  query coordinates, signed, dim k at [k*IN_WIDTH +: IN_WIDTH]
vertex_pos_in  input  DIM*IN_WIDTH  vertex coordinates, same packing
id_in  input  ID_WIDTH  vertex tag
last_in  input  1  beat is the final vertex of the current query batch
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
distance_sq_out  output  OUT_WIDTH  sum over k of (query_k - vertex_k)^2, unsigned
id_out  output  ID_WIDTH  tag of the result
last_out  output  1  last flag of the result
best_valid  output  1  one-cycle pulse: batch minimum available
best_dist_out  output  OUT_WIDTH  minimum distance of the finished batch
best_id_out  output  ID_WIDTH  tag of that minimum

Behaviour:
- Reset (rst_n_in low, asynchronous): all stage valids, out_valid and best_valid go to 0. distance_sq_out, id_out, last_out, best_dist_out and best_id_out go to 0. The running minimum goes to all-ones and the running tag to 0. Release is synchronous to clk_in.
- Pipeline stages, all registered:
  - S1: per-dim difference, IN_WIDTH+1 bits signed, no overflow possible.
  - S2: per-dim square, 2*IN_WIDTH bits unsigned (max (2^IN_WIDTH - 1)^2).
  - S3..S(2+LVL): pairwise adder tree, one level per stage, each level one bit wider.
  - The final tree register drives the outputs directly.
- Latency: 2+LVL cycles from input handshake to out_valid, with no stall. DIM=4 gives 4; DIM=1 gives 2.
- id and last travel in lock-step with the data.
- Flow control: adv = !out_valid || out_ready. in_ready = adv, combinational from out_valid and out_ready only. in_ready never depends on in_valid.
  - When adv=1, every stage loads from its predecessor.
  - When adv=0, every stage holds.
  - Bubbles are not squeezed out.
  - Throughput is 1 beat/cycle with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, distance_sq_out, id_out and last_out stay constant.
- Minimum tracker: acts on each output handshake (out_valid && out_ready).
  - Candidate replaces the running minimum only if strictly less, so ties keep the earliest tag.
  - On a handshake with last_out=1, the cycle after:
    - best_dist_out and best_id_out hold the minimum including that beat;
    - best_valid=1 for exactly one cycle;
    - the running minimum reloads to all-ones.
  - best_* hold their value until the next batch end.
- Single-beat batch (last_in on the first beat): best equals that beat.
- A batch end and the first beat of the next batch on consecutive handshakes: the new beat compares against the freshly reset minimum.
- Reset asserted mid-stream: in-flight beats and the partial batch are discarded. No best_valid pulse is produced.

Optional Feature:
Macro SQ_DIST_L1_MODE_EN.
- Defined: S2 computes |diff| instead of diff^2, zero-extended to 2*IN_WIDTH bits. distance_sq_out is the Manhattan distance. Latency, widths and handshake are unchanged.
- Undefined: squared Euclidean as specified above.

Test Plan:
- DIM=4, IN_WIDTH=16. Query (0,0,0,0), vertex (3,4,0,0), id 9, out_ready=1 -> out_valid exactly 4 cycles after the handshake, distance_sq_out=25, id_out=9.
- Query all -32768, vertex all 32767 -> each square is 4294836225; distance_sq_out = 17179344900. Checks 34-bit width, no truncation.
- Stream 6 back-to-back beats, drop out_ready low for 3 cycles mid-stream. Expected:
  - in_ready low exactly while out_valid=1 and out_ready=0;
  - outputs held stable;
  - all 6 results emerge in order, none lost or duplicated.
- Batch ids 5,6,7 with distances 50,20,20, last on id 7 -> single best_valid pulse with best_dist_out=20, best_id_out=6. A following 1-beat batch (id 8, distance 90) -> best 90/id 8.
- Assert rst_n_in asynchronously (mid-cycle) with 3 beats in flight and a partial batch -> outputs clear immediately; no out_valid or best_valid after release; the next batch reports correctly.
- With SQ_DIST_L1_MODE_EN defined: query (0,0,0,0), vertex (3,-4,1,0) -> distance_sq_out=8, latency 4.

Source files
------------

// File: rtl/sq_dist_pipeline.sv
// Streaming squared-distance engine with valid/ready flow control and per-batch minimum tracking.
// Define SQ_DIST_L1_MODE_EN to compute Manhattan distance instead of squared Euclidean distance.
module sq_dist_pipeline #(
  parameter int unsigned DIM       = 4,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned ID_WIDTH  = 8,
  localparam int unsigned LVL       = (DIM > 1) ? $clog2(DIM) : 0,
  localparam int unsigned OUT_WIDTH = 2*IN_WIDTH + LVL
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*IN_WIDTH-1:0]   query_pos_in,
  input  logic [DIM*IN_WIDTH-1:0]   vertex_pos_in,
  input  logic [ID_WIDTH-1:0]       id_in,
  input  logic                      last_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      distance_sq_out,
  output logic [ID_WIDTH-1:0]       id_out,
  output logic                      last_out,
  output logic                      best_valid,
  output logic [OUT_WIDTH-1:0]      best_dist_out,
  output logic [ID_WIDTH-1:0]       best_id_out
);

  localparam int unsigned NP = 1 << LVL;
  localparam int unsigned NS = 2 + LVL;
  localparam int unsigned DW = IN_WIDTH + 1;
  localparam int unsigned SW = 2*IN_WIDTH;

  logic                        adv;
  logic signed [DW-1:0]        diff_q [DIM];
  logic signed [DW-1:0]        diff_d [DIM];
  // Level 0 holds the per-dim squares; level LVL entry 0 is the final sum.
  logic [OUT_WIDTH-1:0]        tree_q [LVL+1][NP];
  logic [OUT_WIDTH-1:0]        tree_d [LVL+1][NP];
  logic [NS-1:0]               vld_q, vld_d;
  logic [NS-1:0]               last_q, last_d;
  logic [ID_WIDTH-1:0]         id_q [NS];
  logic [ID_WIDTH-1:0]         id_d [NS];

  logic                        hs;
  logic                        take;
  logic [OUT_WIDTH-1:0]        run_dist;
  logic [ID_WIDTH-1:0]         run_id;
  logic [OUT_WIDTH-1:0]        min_q, min_d;
  logic [ID_WIDTH-1:0]         min_id_q, min_id_d;
  logic [OUT_WIDTH-1:0]        best_dist_q, best_dist_d;
  logic [ID_WIDTH-1:0]         best_id_q, best_id_d;
  logic                        best_valid_q, best_valid_d;

  // Whole pipeline advances together; bubbles are kept.
  assign adv      = !vld_q[NS-1] || out_ready;
  assign in_ready = adv;

  always_comb begin : p_datapath
    logic signed [DW-1:0] qk;
    logic signed [DW-1:0] vk;
    logic signed [SW-1:0] dx;
    logic [SW-1:0]        mag;
    for (int k = 0; k < int'(DIM); k++) begin
      qk        = DW'($signed(query_pos_in[k*IN_WIDTH +: IN_WIDTH]));
      vk        = DW'($signed(vertex_pos_in[k*IN_WIDTH +: IN_WIDTH]));
      diff_d[k] = qk - vk;
    end
    for (int l = 0; l <= int'(LVL); l++) begin
      for (int j = 0; j < int'(NP); j++) begin
        tree_d[l][j] = '0;
      end
    end
    for (int j = 0; j < int'(NP); j++) begin
      dx  = '0;
      mag = '0;
      if (j < int'(DIM)) begin
        dx = SW'(diff_q[j]);
`ifdef SQ_DIST_L1_MODE_EN
        mag = dx[SW-1] ? SW'(-dx) : SW'(dx);
`else
        mag = SW'(dx * dx);
`endif
      end
      tree_d[0][j] = OUT_WIDTH'(mag);
    end
    for (int l = 1; l <= int'(LVL); l++) begin
      for (int j = 0; j < int'(NP >> l); j++) begin
        tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
      end
    end
    vld_d  = {vld_q[NS-2:0], in_valid};
    last_d = {last_q[NS-2:0], last_in};
    id_d[0] = id_in;
    for (int s = 1; s < int'(NS); s++) begin
      id_d[s] = id_q[s-1];
    end
  end

  // Running minimum; strict compare keeps the earliest tag on ties.
  always_comb begin : p_min
    hs           = vld_q[NS-1] && out_ready;
    take         = tree_q[LVL][0] < min_q;
    run_dist     = take ? tree_q[LVL][0] : min_q;
    run_id       = take ? id_q[NS-1] : min_id_q;
    min_d        = min_q;
    min_id_d     = min_id_q;
    best_dist_d  = best_dist_q;
    best_id_d    = best_id_q;
    best_valid_d = 1'b0;
    if (hs) begin
      if (last_q[NS-1]) begin
        best_dist_d  = run_dist;
        best_id_d    = run_id;
        best_valid_d = 1'b1;
        min_d        = '1;
        min_id_d     = '0;
      end else begin
        min_d    = run_dist;
        min_id_d = run_id;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int k = 0; k < int'(DIM); k++) diff_q[k] <= '0;
      for (int l = 0; l <= int'(LVL); l++) begin
        for (int j = 0; j < int'(NP); j++) tree_q[l][j] <= '0;
      end
      for (int s = 0; s < int'(NS); s++) id_q[s] <= '0;
    end else if (adv) begin
      vld_q  <= vld_d;
      last_q <= last_d;
      for (int k = 0; k < int'(DIM); k++) diff_q[k] <= diff_d[k];
      for (int l = 0; l <= int'(LVL); l++) begin
        for (int j = 0; j < int'(NP); j++) tree_q[l][j] <= tree_d[l][j];
      end
      for (int s = 0; s < int'(NS); s++) id_q[s] <= id_d[s];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      min_q        <= '1;
      min_id_q     <= '0;
      best_dist_q  <= '0;
      best_id_q    <= '0;
      best_valid_q <= 1'b0;
    end else begin
      min_q        <= min_d;
      min_id_q     <= min_id_d;
      best_dist_q  <= best_dist_d;
      best_id_q    <= best_id_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign out_valid       = vld_q[NS-1];
  assign distance_sq_out = tree_q[LVL][0];
  assign id_out          = id_q[NS-1];
  assign last_out        = last_q[NS-1];
  assign best_valid      = best_valid_q;
  assign best_dist_out   = best_dist_q;
  assign best_id_out     = best_id_q;

endmodule

// File: tb/tb_sq_dist_pipeline.sv
// Self-checking bench for sq_dist_pipeline: vector table, directed corner sequences, random stream vs. model.
module tb_sq_dist_pipeline;

  localparam int DIM = 4;
  localparam int W   = 16;
  localparam int IDW = 8;
  localparam int OW  = 34;

`ifdef SQ_DIST_L1_MODE_EN
  localparam longint B_FIRST = 6, B_SINGLE = 12, B_AFTER_RST = 4;
`else
  localparam longint B_FIRST = 20, B_SINGLE = 90, B_AFTER_RST = 8;
`endif

  logic                 clk_in = 1'b0;
  logic                 rst_n_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [DIM*W-1:0]     query_pos_in;
  logic [DIM*W-1:0]     vertex_pos_in;
  logic [IDW-1:0]       id_in;
  logic                 last_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        distance_sq_out;
  logic [IDW-1:0]       id_out;
  logic                 last_out;
  logic                 best_valid;
  logic [OW-1:0]        best_dist_out;
  logic [IDW-1:0]       best_id_out;

  sq_dist_pipeline #(.DIM(DIM), .IN_WIDTH(W), .ID_WIDTH(IDW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .in_valid(in_valid), .in_ready(in_ready),
    .query_pos_in(query_pos_in), .vertex_pos_in(vertex_pos_in), .id_in(id_in),
    .last_in(last_in), .out_valid(out_valid), .out_ready(out_ready),
    .distance_sq_out(distance_sq_out), .id_out(id_out), .last_out(last_out),
    .best_valid(best_valid), .best_dist_out(best_dist_out), .best_id_out(best_id_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [63:0] q;
    logic [63:0] v;
    logic [7:0]  id;
    longint      e2;
    longint      e1;
  } vec_t;

  typedef struct {
    longint   d;
    logic [7:0] id;
    logic     last;
  } res_t;

  int     checks = 0;
  int     errors = 0;
  int     n_out  = 0;
  res_t   exp_q[$];
  res_t   batch[$];
  bit     best_pend = 0;
  longint eb_d;
  logic [7:0] eb_id;
  bit     prev_stall = 0;
  logic [OW-1:0] prev_d;
  logic [IDW-1:0] prev_id;
  logic   prev_last;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Reference distance from plain signed arithmetic.
  function automatic longint model(input logic [63:0] q, input logic [63:0] v);
    longint s = 0;
    for (int k = 0; k < DIM; k++) begin
      longint a, b, d;
      a = longint'($signed(q[k*16 +: 16]));
      b = longint'($signed(v[k*16 +: 16]));
      d = a - b;
`ifdef SQ_DIST_L1_MODE_EN
      s += (d < 0) ? -d : d;
`else
      s += d * d;
`endif
    end
    return s;
  endfunction

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      exp_q.delete();
      batch.delete();
      best_pend  = 0;
      prev_stall = 0;
    end else begin
      chk(best_valid == best_pend, "best_valid", longint'(best_valid), longint'(best_pend));
      if (best_pend) begin
        chk(longint'(best_dist_out) == eb_d, "best_dist", longint'(best_dist_out), eb_d);
        chk(best_id_out == eb_id, "best_id", longint'(best_id_out), longint'(eb_id));
      end
      best_pend = 0;
      chk(in_ready == (!out_valid || out_ready), "in_ready", longint'(in_ready),
          longint'(!out_valid || out_ready));
      if (prev_stall) begin
        chk(out_valid && distance_sq_out == prev_d && id_out == prev_id && last_out == prev_last,
            "hold_stable", longint'(distance_sq_out), longint'(prev_d));
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = distance_sq_out;
      prev_id    = id_out;
      prev_last  = last_out;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk(0, "unexpected_out", longint'(id_out), -1);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk(longint'(distance_sq_out) == e.d, "dist", longint'(distance_sq_out), e.d);
          chk(id_out == e.id, "id", longint'(id_out), longint'(e.id));
          chk(last_out == e.last, "last", longint'(last_out), longint'(e.last));
          batch.push_back(e);
          if (e.last) begin
            eb_d  = batch[0].d;
            eb_id = batch[0].id;
            foreach (batch[i]) if (batch[i].d < eb_d) begin
              eb_d  = batch[i].d;
              eb_id = batch[i].id;
            end
            batch.delete();
            best_pend = 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        res_t r;
        r.d = model(query_pos_in, vertex_pos_in);
        r.id = id_in;
        r.last = last_in;
        exp_q.push_back(r);
      end
    end
  end

  task automatic drive(input logic [63:0] q, input logic [63:0] v, input logic [7:0] id,
                       input logic last);
    int n = 0;
    @(posedge clk_in) #1;
    in_valid = 1'b1; query_pos_in = q; vertex_pos_in = v; id_in = id; last_in = last;
    do begin
      @(negedge clk_in);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk(0, "accept_timeout", n, 50);
  endtask

  task automatic idle();
    @(posedge clk_in) #1;
    in_valid = 1'b0; last_in = 1'b0;
  endtask

  task automatic wait_best(input longint d, input logic [7:0] id, input string tag);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!best_valid && n < 30);
    chk(best_valid, {tag, "_pulse"}, longint'(best_valid), 1);
    chk(longint'(best_dist_out) == d, {tag, "_dist"}, longint'(best_dist_out), d);
    chk(best_id_out == id, {tag, "_id"}, longint'(best_id_out), longint'(id));
    @(negedge clk_in);
    chk(!best_valid, {tag, "_one_cycle"}, longint'(best_valid), 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    chk(exp_q.size() == 0, tag, exp_q.size(), 0);
  endtask

  vec_t tbl[6];

  initial begin
    int lat, base;
    tbl[0] = '{pk(0,0,0,0), pk(3,4,0,0), 8'd1, 25, 7};
    tbl[1] = '{pk(-32768,-32768,-32768,-32768), pk(32767,32767,32767,32767), 8'd2,
               64'sd17179344900, 262140};
    tbl[2] = '{pk(1,2,3,4), pk(1,2,3,4), 8'd3, 0, 0};
    tbl[3] = '{pk(-5,0,7,0), pk(5,0,-1,0), 8'd4, 164, 18};
    tbl[4] = '{pk(100,-100,0,0), pk(-100,100,0,0), 8'd5, 80000, 400};
    tbl[5] = '{pk(0,0,0,0), pk(3,-4,1,0), 8'd6, 26, 8};

    rst_n_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1; last_in = 1'b0;
    query_pos_in = '0; vertex_pos_in = '0; id_in = '0;
    #12;
    chk(!out_valid, "rst_out_valid", longint'(out_valid), 0);
    chk(!best_valid, "rst_best_valid", longint'(best_valid), 0);
    chk(distance_sq_out == '0 && id_out == '0 && !last_out, "rst_out_data",
        longint'(distance_sq_out), 0);
    chk(best_dist_out == '0 && best_id_out == '0, "rst_best_data", longint'(best_dist_out), 0);
    chk(in_ready, "rst_in_ready", longint'(in_ready), 1);
    @(posedge clk_in) #3 rst_n_in = 1'b1;

    // Single-beat batches from the table: latency, value, and best equals the beat.
    for (int i = 0; i < 6; i++) begin
      longint e;
`ifdef SQ_DIST_L1_MODE_EN
      e = tbl[i].e1;
`else
      e = tbl[i].e2;
`endif
      drive(tbl[i].q, tbl[i].v, tbl[i].id, 1'b1);
      idle();
      lat = 0;
      do begin
        @(negedge clk_in);
        lat++;
      end while (!out_valid && lat < 20);
      chk(lat == 4, "latency", lat, 4);
      chk(longint'(distance_sq_out) == e, "tbl_dist", longint'(distance_sq_out), e);
      chk(id_out == tbl[i].id, "tbl_id", longint'(id_out), longint'(tbl[i].id));
      repeat (2) @(negedge clk_in);
    end

    // Six back-to-back beats with a three-cycle downstream stall.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          drive({$urandom, $urandom}, {$urandom, $urandom}, 8'(20 + i), i == 5);
        idle();
      end
      begin
        repeat (5) @(posedge clk_in);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk(n_out - base == 6, "bp_count", n_out - base, 6);

    // Batch with a tie, then a single-beat batch.
    drive(pk(0,0,0,0), pk(5,5,0,0), 8'd5, 1'b0);
    drive(pk(0,0,0,0), pk(4,2,0,0), 8'd6, 1'b0);
    drive(pk(0,0,0,0), pk(2,4,0,0), 8'd7, 1'b1);
    idle();
    wait_best(B_FIRST, 8'd6, "batch_tie");
    drive(pk(0,0,0,0), pk(9,3,0,0), 8'd8, 1'b1);
    idle();
    wait_best(B_SINGLE, 8'd8, "batch_single");

    // Asynchronous reset with a partial batch and three beats in flight.
    drive(pk(0,0,0,0), pk(1,1,0,0), 8'd30, 1'b0);
    idle();
    repeat (5) @(negedge clk_in);
    drive(pk(0,0,0,0), pk(2,0,0,0), 8'd31, 1'b0);
    drive(pk(0,0,0,0), pk(0,2,0,0), 8'd32, 1'b0);
    drive(pk(0,0,0,0), pk(0,0,2,0), 8'd33, 1'b0);
    idle();
    @(posedge clk_in) #3;
    chk(out_valid, "pre_rst_busy", longint'(out_valid), 1);
    rst_n_in = 1'b0;
    #1;
    chk(!out_valid && distance_sq_out == '0 && id_out == '0, "async_rst_out",
        longint'(out_valid), 0);
    chk(!best_valid && best_dist_out == '0 && best_id_out == '0, "async_rst_best",
        longint'(best_dist_out), 0);
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      chk(!out_valid && !best_valid, "post_rst_quiet", longint'(out_valid), 0);
    end
    drive(pk(0,0,0,0), pk(3,4,0,0), 8'd40, 1'b0);
    drive(pk(0,0,0,0), pk(2,2,0,0), 8'd41, 1'b1);
    idle();
    wait_best(B_AFTER_RST, 8'd41, "after_rst");

    // Random stream against the model, with random backpressure and batch ends.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_in) #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      id_in     = 8'($urandom);
      last_in   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        query_pos_in  = {4{16'h8000}};
        vertex_pos_in = {4{16'h7fff}};
      end else begin
        query_pos_in  = {$urandom, $urandom};
        vertex_pos_in = {$urandom, $urandom};
      end
    end
    @(posedge clk_in) #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand_drain");
    repeat (3) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
